// File: rtl/prog_loader_if.sv
// prog_loader_if: bundles the loader's byte stream, instruction memory write
// port and core control/status lines into one connection.
//   load_req, byte_valid, byte_data : stream source -> loader
//   byte_ready                      : loader -> stream source
//   imem_we, imem_addr, imem_wdata  : loader -> instruction memory
//   cpu_enable, pc_clear            : loader -> core (PC enable / PC clear)
//   busy, done, error               : loader status
// The master modport is the stream source / system side.
// The slave modport is the loader itself.
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) ();
  logic                  load_req;
  logic                  byte_valid;
  logic [DATA_WIDTH-1:0] byte_data;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;
  logic                  cpu_enable;
  logic                  pc_clear;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output load_req, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata,
    input  cpu_enable, pc_clear, busy, done, error
  );

  modport slave (
    input  load_req, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata,
    output cpu_enable, pc_clear, busy, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream (length N, N instruction bytes,
// checksum) and writes the instruction bytes to instruction memory addresses
// 0..N-1. The core is held stalled while loading. A frame with a good checksum
// pulses pc_clear and then releases the core. A bad, empty or stalled frame
// parks the loader in an error state with the core halted.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - prog_loader_if.slave. It carries the stream handshake, the imem
//           write port and the core control/status outputs. All outputs are
//           registered.
module prog_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1000
) (
  input logic          clk,
  input logic          reset,
  prog_loader_if.slave bus
);

  // The index and length counters must be wide enough to hold N itself,
  // so they carry one bit more than the wider of address and data.
  localparam int CNT_W = ((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH) + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, RUN, ERR} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      frameLen_q, frameLen_d;
  logic [CNT_W-1:0]      index_q, index_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [TO_W-1:0]       idleCnt_q, idleCnt_d;

  logic                  byteReady_q, byteReady_d;
  logic                  imemWe_q, imemWe_d;
  logic [ADDR_WIDTH-1:0] imemAddr_q, imemAddr_d;
  logic [DATA_WIDTH-1:0] imemWdata_q, imemWdata_d;
  logic                  cpuEnable_q, cpuEnable_d;
  logic                  pcClear_q, pcClear_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic [TO_W-1:0]       idleCntInc;

  // byte_ready is registered and tracks the state register, so a transfer is
  // simply valid together with the ready value currently presented.
  assign accept     = bus.byte_valid && byteReady_q;
  assign idleCntInc = idleCnt_q + 1'b1;

  // State and output registers. Reset drops everything to zero, which also
  // halts the core until a good program has been loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      frameLen_q  <= '0;
      index_q     <= '0;
      sum_q       <= '0;
      idleCnt_q   <= '0;
      byteReady_q <= 1'b0;
      imemWe_q    <= 1'b0;
      imemAddr_q  <= '0;
      imemWdata_q <= '0;
      cpuEnable_q <= 1'b0;
      pcClear_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      frameLen_q  <= frameLen_d;
      index_q     <= index_d;
      sum_q       <= sum_d;
      idleCnt_q   <= idleCnt_d;
      byteReady_q <= byteReady_d;
      imemWe_q    <= imemWe_d;
      imemAddr_q  <= imemAddr_d;
      imemWdata_q <= imemWdata_d;
      cpuEnable_q <= cpuEnable_d;
      pcClear_q   <= pcClear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Next-state logic: frame parsing, the running checksum and the inter-byte
  // stall counter. An accepted byte always clears the stall counter, so a
  // byte arriving on the edge that would time out wins over the timeout.
  always_comb begin
    state_d    = state_q;
    frameLen_d = frameLen_q;
    index_d    = index_q;
    sum_d      = sum_q;
    idleCnt_d  = idleCnt_q;
    case (state_q)
      IDLE, RUN, ERR: begin
        if (bus.load_req) begin
          state_d    = LEN;
          frameLen_d = '0;
          index_d    = '0;
          sum_d      = '0;
          idleCnt_d  = '0;
        end
      end
      LEN, DATA, CSUM: begin
        if (accept) begin
          idleCnt_d = '0;
          if (state_q == LEN) begin
            if (bus.byte_data == '0) begin
              state_d = ERR;
            end else begin
              frameLen_d = CNT_W'(bus.byte_data);
              state_d    = DATA;
            end
          end else if (state_q == DATA) begin
            index_d = index_q + 1'b1;
            sum_d   = sum_q + bus.byte_data;
            if (index_d == frameLen_q) begin
              state_d = CSUM;
            end
          end else begin
            state_d = (bus.byte_data == sum_q) ? RUN : ERR;
          end
        end else begin
          idleCnt_d = idleCntInc;
          if (idleCntInc == TO_LIMIT) begin
            state_d = ERR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. The first RUN cycle
  // carries pc_clear with the core still disabled. The core is enabled only
  // from the second RUN cycle onwards, so the PC restarts from zero.
  always_comb begin
    byteReady_d = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
    busy_d      = byteReady_d;
    done_d      = (state_d == RUN);
    error_d     = (state_d == ERR);
    pcClear_d   = (state_q == CSUM) && (state_d == RUN);
    cpuEnable_d = (state_q == RUN) && (state_d == RUN);
    imemWe_d    = (state_q == DATA) && accept;
    imemAddr_d  = imemAddr_q;
    imemWdata_d = imemWdata_q;
    if (imemWe_d) begin
      imemAddr_d  = index_q[ADDR_WIDTH-1:0];
      imemWdata_d = bus.byte_data;
    end
  end

  assign bus.byte_ready = byteReady_q;
  assign bus.imem_we    = imemWe_q;
  assign bus.imem_addr  = imemAddr_q;
  assign bus.imem_wdata = imemWdata_q;
  assign bus.cpu_enable = cpuEnable_q;
  assign bus.pc_clear   = pcClear_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: drives framed byte streams into prog_loader and compares
// the memory writes and core control outputs against a frame-level model.
// The model states the outcome directly: a frame is good exactly when N is
// nonzero and the byte sum mod 256 equals the checksum. Byte i then lands at
// address i.
module tb_prog_loader;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 10;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  logic [15:0] writes[$];
  int   pcClearCycles = 0;

  prog_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Records every memory write and every pc_clear cycle on the falling edge.
  // Tests read these records one time unit later.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.imem_we) writes.push_back({bus.imem_addr, bus.imem_wdata});
      if (bus.pc_clear) pcClearCycles++;
    end
  end

  // Hard stop in case something blocks forever.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Moves to just after the next falling edge, where inputs are driven and
  // outputs are sampled.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Good-frame predicate of the reference model.
  function automatic bit frameIsGood(input logic [7:0] frame[$]);
    int n;
    int s;
    n = frame[0];
    if (n == 0) return 1'b0;
    s = 0;
    for (int i = 1; i <= n; i++) s += frame[i];
    return (s % 256) == frame[n + 1];
  endfunction

  // Builds a frame: length, data, and a checksum that is correct or corrupted.
  function automatic void buildFrame(input logic [7:0] data[$], input bit good,
                                     output logic [7:0] frame[$]);
    int s;
    s = 0;
    frame = {};
    frame.push_back(8'(data.size()));
    foreach (data[i]) begin
      frame.push_back(data[i]);
      s += data[i];
    end
    frame.push_back(good ? 8'(s % 256) : 8'(s % 256) ^ 8'($urandom_range(1, 255)));
  endfunction

  // Pulses load_req for one cycle.
  task automatic startFrame();
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
  endtask

  // Offers one byte after an idle gap. The idle cycles carry garbage data and
  // optionally stray load_req pulses. Returns once the byte has transferred,
  // or after a bounded wait.
  task automatic applyStimulus(input logic [7:0] b, input int gap, input bit noise,
                               output bit ok);
    for (int g = 0; g < gap; g++) begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
      bus.load_req   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    bus.load_req   = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.byte_ready) ok = 1'b1;
      tick();
    end
    bus.byte_valid = 1'b0;
  endtask

  // Sends a whole frame with random gaps up to maxGap cycles.
  task automatic sendFrame(input logic [7:0] frame[$], input int maxGap, input bit noise,
                           output int accepted);
    bit ok;
    accepted = 0;
    foreach (frame[i]) begin
      applyStimulus(frame[i], $urandom_range(0, maxGap), noise, ok);
      if (ok) accepted++;
    end
  endtask

  // Full frame check against the model: transfers, writes, outcome, pc_clear.
  task automatic checkOutput(input string name, input logic [7:0] frame[$], input int accepted);
    bit          good;
    logic [15:0] got;
    logic [15:0] exp;
    good = frameIsGood(frame);
    vectors++;
    if (accepted !== frame.size()) begin
      miscompares++;
      $display("[TB] FAIL %s accepted: got %0d expected %0d", name, accepted, frame.size());
    end
    vectors++;
    if (writes.size() !== int'(frame[0])) begin
      miscompares++;
      $display("[TB] FAIL %s write count: got %0d expected %0d", name, writes.size(), frame[0]);
    end
    for (int i = 0; i < int'(frame[0]); i++) begin
      exp = {8'(i), frame[i + 1]};
      got = (i < writes.size()) ? writes[i] : 16'hxxxx;
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL %s write[%0d]: got %h expected %h", name, i, got, exp);
      end
    end
    vectors++;
    if ({bus.done, bus.error, bus.cpu_enable, bus.busy} !== (good ? 4'b1010 : 4'b0100)) begin
      miscompares++;
      $display("[TB] FAIL %s status done/err/en/busy: got %b expected %b", name,
               {bus.done, bus.error, bus.cpu_enable, bus.busy}, good ? 4'b1010 : 4'b0100);
    end
    vectors++;
    if (pcClearCycles !== int'(good)) begin
      miscompares++;
      $display("[TB] FAIL %s pc_clear cycles: got %0d expected %0d", name, pcClearCycles, good);
    end
  endtask

  task automatic test_reset();
    bus.load_req   = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_enable,
         bus.pc_clear, bus.busy, bus.done, bus.error} !== 23'd0) begin
      miscompares++;
      $display("[TB] FAIL reset outputs: got %h expected 0", {bus.byte_ready, bus.imem_we,
               bus.imem_addr, bus.imem_wdata, bus.cpu_enable, bus.pc_clear, bus.busy,
               bus.done, bus.error});
    end
    reset = 1'b0;
    bus.byte_valid = 1'b1;
    tick();
    tick();
    bus.byte_valid = 1'b0;
    vectors++;
    if ({bus.byte_ready, bus.busy, bus.cpu_enable, bus.imem_we} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL idle after reset: got %b expected 0000",
               {bus.byte_ready, bus.busy, bus.cpu_enable, bus.imem_we});
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] data[3] = '{8'h11, 8'h22, 8'h33};
    bit ok;
    writes.delete();
    pcClearCycles = 0;
    startFrame();
    vectors++;
    if ({bus.busy, bus.byte_ready, bus.cpu_enable, bus.done, bus.error} !== 5'b11000) begin
      miscompares++;
      $display("[TB] FAIL load start: got %b expected 11000",
               {bus.busy, bus.byte_ready, bus.cpu_enable, bus.done, bus.error});
    end
    applyStimulus(8'h03, 0, 1'b0, ok);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(data[i], 0, 1'b0, ok);
      vectors++;
      if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 8'(i), data[i]}) begin
        miscompares++;
        $display("[TB] FAIL write latency[%0d]: got %h expected %h", i,
                 {bus.imem_we, bus.imem_addr, bus.imem_wdata}, {1'b1, 8'(i), data[i]});
      end
    end
    applyStimulus(8'h66, 0, 1'b0, ok);
    vectors++;
    if ({bus.pc_clear, bus.done, bus.busy, bus.cpu_enable, bus.error, bus.imem_we} !== 6'b110000) begin
      miscompares++;
      $display("[TB] FAIL run entry: got %b expected 110000",
               {bus.pc_clear, bus.done, bus.busy, bus.cpu_enable, bus.error, bus.imem_we});
    end
    tick();
    vectors++;
    if ({bus.pc_clear, bus.cpu_enable, bus.done, bus.error} !== 4'b0110) begin
      miscompares++;
      $display("[TB] FAIL run steady: got %b expected 0110",
               {bus.pc_clear, bus.cpu_enable, bus.done, bus.error});
    end
    repeat (3) tick();
    vectors++;
    if (pcClearCycles !== 1 || writes.size() !== 3) begin
      miscompares++;
      $display("[TB] FAIL good frame totals: got pc_clear=%0d writes=%0d expected 1 and 3",
               pcClearCycles, writes.size());
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] frame[$] = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h65};
    int acc;
    writes.delete();
    pcClearCycles = 0;
    startFrame();
    sendFrame(frame, 0, 1'b0, acc);
    repeat (2) tick();
    checkOutput("bad checksum", frame, acc);
  endtask

  task automatic test_zero_length();
    bit ok;
    writes.delete();
    pcClearCycles = 0;
    startFrame();
    applyStimulus(8'h00, 0, 1'b0, ok);
    vectors++;
    if ({ok, bus.error, bus.busy, bus.byte_ready, bus.cpu_enable} !== 5'b11000) begin
      miscompares++;
      $display("[TB] FAIL zero length: got %b expected 11000",
               {ok, bus.error, bus.busy, bus.byte_ready, bus.cpu_enable});
    end
    repeat (2) tick();
    vectors++;
    if (writes.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL zero length writes: got %0d expected 0", writes.size());
    end
  endtask

  task automatic test_timeout();
    logic [7:0] frame[$] = '{8'h03, 8'h07, 8'h09, 8'h0A, 8'h1A};
    bit ok;
    int k;
    int acc;
    writes.delete();
    pcClearCycles = 0;
    startFrame();
    applyStimulus(8'h02, 0, 1'b0, ok);
    applyStimulus(8'h05, 0, 1'b0, ok);
    k = 0;
    while (!bus.error && k < 40) begin
      tick();
      k++;
    end
    vectors++;
    if (k !== TO) begin
      miscompares++;
      $display("[TB] FAIL timeout cycles: got %0d expected %0d", k, TO);
    end
    vectors++;
    if (writes.size() !== 1 || (writes.size() > 0 && writes[0] !== 16'h0005)) begin
      miscompares++;
      $display("[TB] FAIL timeout writes: got %0d entries first %h expected 1 entry 0005",
               writes.size(), writes.size() > 0 ? writes[0] : 16'hxxxx);
    end
    writes.delete();
    pcClearCycles = 0;
    startFrame();
    sendFrame(frame, 0, 1'b0, acc);
    tick();
    checkOutput("timeout recovery", frame, acc);
  endtask

  task automatic test_valid_toggle();
    logic [7:0] frame[$] = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    int acc;
    writes.delete();
    pcClearCycles = 0;
    startFrame();
    sendFrame(frame, 3, 1'b1, acc);
    tick();
    checkOutput("valid toggle", frame, acc);
  endtask

  task automatic test_async_reset();
    logic [7:0] data[$];
    logic [7:0] frame[$];
    bit ok;
    int acc;
    startFrame();
    applyStimulus(8'h05, 0, 1'b0, ok);
    applyStimulus(8'hAA, 0, 1'b0, ok);
    applyStimulus(8'hBB, 0, 1'b0, ok);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_enable,
         bus.pc_clear, bus.busy, bus.done, bus.error} !== 23'd0) begin
      miscompares++;
      $display("[TB] FAIL async reset outputs: got %h expected 0", {bus.byte_ready,
               bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_enable, bus.pc_clear,
               bus.busy, bus.done, bus.error});
    end
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) data.push_back(8'($urandom));
    buildFrame(data, 1'b1, frame);
    writes.delete();
    pcClearCycles = 0;
    startFrame();
    sendFrame(frame, 2, 1'b0, acc);
    tick();
    checkOutput("after async reset", frame, acc);
  endtask

  task automatic test_random_frames();
    logic [7:0] data[$];
    logic [7:0] frame[$];
    int acc;
    for (int f = 0; f < 8; f++) begin
      data = {};
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) data.push_back(8'($urandom));
      buildFrame(data, 1'($urandom_range(0, 1)), frame);
      writes.delete();
      pcClearCycles = 0;
      startFrame();
      sendFrame(frame, 4, 1'b1, acc);
      tick();
      checkOutput($sformatf("random frame %0d", f), frame, acc);
    end
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    reset = 1'b1;
    bus.load_req   = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_zero_length();
    test_timeout();
    test_valid_toggle();
    test_async_reset();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Byte-stream program loader that writes the instruction memory, which the core otherwise only reads through the PC. It accepts a framed stream (length, instruction bytes, checksum) over a valid/ready handshake and writes each byte to consecutive instruction addresses starting at 0. It holds the core stalled through the PC enable while loading. On a good checksum it pulses a PC clear and releases the core. A bad frame leaves the core halted.

Parameters:
ADDR_WIDTH, 8, instruction memory address width (one byte per address)
DATA_WIDTH, 8, instruction width
TIMEOUT, 1000, maximum cycles between accepted bytes while a frame is open; minimum 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
load_req  input  1  request to start a new frame
byte_valid  input  1  byte_data is valid
byte_data  input  DATA_WIDTH  stream byte
byte_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction memory write strobe
imem_addr  output  ADDR_WIDTH  write address
imem_wdata  output  DATA_WIDTH  write data
cpu_enable  output  1  drives the PC enable
pc_clear  output  1  one-cycle PC reset pulse
busy  output  1  a frame is in progress
done  output  1  last frame loaded with a good checksum
error  output  1  last frame failed

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high on port reset.
- All outputs are registered.
- On reset:
  - state IDLE.
  - All outputs 0. cpu_enable=0, so the core stays halted until a program is loaded.
  - Counters and checksum cleared.
  - Reset mid-frame aborts the frame immediately. Bytes already written stay in memory.
- States: IDLE, LEN, DATA, CSUM, RUN, ERR.
- Handshake:
  - A byte transfers on a rising edge with byte_valid=1 and byte_ready=1.
  - byte_ready=1 only in LEN, DATA and CSUM.
  - byte_valid with byte_ready=0 is ignored; no data is lost to the loader.
- IDLE, RUN or ERR with load_req=1 goes to LEN. On that edge:
  - cpu_enable<=0, busy<=1, done<=0, error<=0.
  - index<=0, sum<=0, timeout counter<=0.
- load_req is ignored in LEN, DATA and CSUM.
- LEN:
  - The accepted byte is N, the instruction count.
  - N=0 goes to ERR.
  - Otherwise store N and go to DATA.
- DATA:
  - Each accepted byte b produces, in the cycle after the accept edge: imem_we=1, imem_addr=index, imem_wdata=b.
  - Update index<=index+1 and sum<=(sum+b) mod 2^DATA_WIDTH.
  - After the Nth byte, go to CSUM.
  - imem_we is a single-cycle pulse per byte; it is 0 in all other cycles.
- CSUM:
  - If the accepted byte equals sum, go to RUN. On that edge: pc_clear<=1, done<=1, busy<=0.
  - On the next edge: pc_clear<=0, cpu_enable<=1.
  - A mismatch goes to ERR.
- ERR: busy=0, error=1, cpu_enable=0. Stays in ERR until load_req or reset.
- RUN: cpu_enable=1 and done=1 until the next load_req.
- Timeout:
  - The counter increments each cycle in LEN, DATA and CSUM without an accepted byte, and clears on each accept.
  - Reaching TIMEOUT goes to ERR; a partial frame is not rolled back.
- Wrap: with ADDR_WIDTH=8, N≤255, so index never wraps within a frame.
- Simultaneous events:
  - A byte accepted on the same edge the counter would reach TIMEOUT counts as accepted; no timeout.
  - load_req on the same edge as entering RUN or ERR is not seen until the following cycle.

Test Plan:
1. Reset, then load_req, then stream 03, 11, 22, 33, 66 -> imem_we pulses at addresses 0, 1, 2 with data 11, 22, 33. pc_clear is 1 for exactly one cycle. After that, cpu_enable=1, done=1, error=0.
2. Same frame with checksum 65 -> ERR. error=1, cpu_enable=0, pc_clear never asserts, and the three writes still occur.
3. Length byte 00 -> ERR on the next edge. No imem_we.
4. TIMEOUT=10; after 02, 05, stall byte_valid for 10 cycles -> ERR. One write to address 0 with data 05. Assert load_req with a valid frame afterwards -> recovers to RUN.
5. byte_valid toggled randomly during a 4-byte frame (01, 02, 03, 04, checksum 0A) -> writes occur only on handshake edges, in order, and the frame reaches RUN. load_req pulsed mid-frame -> no effect.
6. Assert reset asynchronously mid-DATA between clock edges -> all outputs 0 at once, state IDLE. A subsequent full frame loads correctly from address 0.
